// File: rtl/reservation_station.sv
// reservation_station
//   Central reservation station in front of the ALU. Issued instructions carry
//   operands that are either immediate values or ROB tags. Pending operands are
//   captured from the ROB broadcast (done_rob/data_rob). Ready entries are
//   dispatched to the ALU lowest index first. Each ALU result is published on
//   done_rs/data_rs for one cycle, and the reorder buffer snoops that broadcast.
//
//   Handshake: alu_req_valid/alu_req_ready follow valid/ready semantics. A request
//   transfers on a cycle where both are high. The request fields remain stable
//   while valid is high and ready is low. The one exception is that a lower-index
//   entry becoming READY may take over the request.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   issue_valid/op/src1_tag/src1/   instruction issue from the decoder
//     src2_tag/src2
//   alloc_idx, rs_full              next entry to fill; no free entry
//   done_rob, data_rob              ROB result broadcast (snooped)
//   alu_req_*                       dispatch request (combinational)
//   alu_resp_valid/tag/data         ALU result return
//   done_rs, data_rs                per-entry result broadcast (registered)
//   dbg_state_o                     per-entry state, for checkers
module reservation_station #(
  parameter int rs_size        = 16,
  parameter int rs_index_bits  = 4,
  parameter int rob_size       = 16,
  parameter int rob_index_bits = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  input  logic [3:0]                         issue_op,
  input  logic                               issue_src1_tag,
  input  logic [31:0]                        issue_src1,
  input  logic                               issue_src2_tag,
  input  logic [31:0]                        issue_src2,
  output logic [rs_index_bits-1:0]           alloc_idx,
  output logic                               rs_full,
  input  logic [rob_size-1:0]                done_rob,
  input  logic [rob_size-1:0][31:0]          data_rob,
  output logic                               alu_req_valid,
  input  logic                               alu_req_ready,
  output logic [3:0]                         alu_req_op,
  output logic [31:0]                        alu_req_a,
  output logic [31:0]                        alu_req_b,
  output logic [rs_index_bits-1:0]           alu_req_tag,
  input  logic                               alu_resp_valid,
  input  logic [rs_index_bits-1:0]           alu_resp_tag,
  input  logic [31:0]                        alu_resp_data,
  output logic [rs_size-1:0]                 done_rs,
  output logic [rs_size-1:0][31:0]           data_rs,
  output logic [rs_size-1:0][2:0]            dbg_state_o
);

  typedef enum logic [2:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC, ST_DONE} state_t;

  state_t                    st_q    [rs_size];
  state_t                    st_d    [rs_size];
  logic [3:0]                op_q    [rs_size];
  logic [3:0]                op_d    [rs_size];
  logic [31:0]               a_q     [rs_size];
  logic [31:0]               a_d     [rs_size];
  logic [31:0]               b_q     [rs_size];
  logic [31:0]               b_d     [rs_size];
  logic                      a_rdy_q [rs_size];
  logic                      a_rdy_d [rs_size];
  logic                      b_rdy_q [rs_size];
  logic                      b_rdy_d [rs_size];
  logic [rob_index_bits-1:0] a_tag_q [rs_size];
  logic [rob_index_bits-1:0] a_tag_d [rs_size];
  logic [rob_index_bits-1:0] b_tag_q [rs_size];
  logic [rob_index_bits-1:0] b_tag_d [rs_size];
  logic [rs_size-1:0]        done_rs_q, done_rs_d;
  logic [rs_size-1:0][31:0]  data_rs_q, data_rs_d;

  logic [rs_index_bits-1:0]  sel_idx;
  logic                      issue_fire;

  // Operand decode at issue. A tag whose ROB result is already broadcast this
  // cycle is captured immediately.
  logic [rob_index_bits-1:0] iss_a_tag, iss_b_tag;
  logic [31:0]               iss_a_val, iss_b_val;
  logic                      iss_a_rdy, iss_b_rdy;

  always_comb begin
    iss_a_tag = issue_src1[rob_index_bits-1:0];
    iss_b_tag = issue_src2[rob_index_bits-1:0];
    iss_a_val = issue_src1;
    iss_a_rdy = 1'b1;
    iss_b_val = issue_src2;
    iss_b_rdy = 1'b1;
    if (issue_src1_tag) begin
      iss_a_rdy = done_rob[iss_a_tag];
      iss_a_val = done_rob[iss_a_tag] ? data_rob[iss_a_tag] : 32'd0;
    end
    if (issue_src2_tag) begin
      iss_b_rdy = done_rob[iss_b_tag];
      iss_b_val = done_rob[iss_b_tag] ? data_rob[iss_b_tag] : 32'd0;
    end
  end

  // Free-slot and dispatch priority encoders. The loops scan downward so that
  // the lowest matching index is the one that remains selected.
  always_comb begin
    alloc_idx     = '0;
    rs_full       = 1'b1;
    sel_idx       = '0;
    alu_req_valid = 1'b0;
    for (int i = rs_size - 1; i >= 0; i--) begin
      if (st_q[i] == ST_FREE) begin
        alloc_idx = rs_index_bits'(i);
        rs_full   = 1'b0;
      end
      if (st_q[i] == ST_READY) begin
        sel_idx       = rs_index_bits'(i);
        alu_req_valid = 1'b1;
      end
    end
  end

  assign issue_fire  = issue_valid && !rs_full;
  assign alu_req_op  = alu_req_valid ? op_q[sel_idx] : 4'd0;
  assign alu_req_a   = alu_req_valid ? a_q[sel_idx]  : 32'd0;
  assign alu_req_b   = alu_req_valid ? b_q[sel_idx]  : 32'd0;
  assign alu_req_tag = alu_req_valid ? sel_idx       : '0;
  assign done_rs     = done_rs_q;
  assign data_rs     = data_rs_q;

  always_comb begin
    for (int i = 0; i < rs_size; i++) dbg_state_o[i] = st_q[i];
  end

  // Per-entry next-state logic.
  always_comb begin
    done_rs_d = '0;
    data_rs_d = data_rs_q;
    for (int i = 0; i < rs_size; i++) begin
      st_d[i]    = st_q[i];
      op_d[i]    = op_q[i];
      a_d[i]     = a_q[i];
      b_d[i]     = b_q[i];
      a_rdy_d[i] = a_rdy_q[i];
      b_rdy_d[i] = b_rdy_q[i];
      a_tag_d[i] = a_tag_q[i];
      b_tag_d[i] = b_tag_q[i];
      case (st_q[i])
        ST_FREE: begin
          if (issue_fire && alloc_idx == rs_index_bits'(i)) begin
            op_d[i]    = issue_op;
            a_d[i]     = iss_a_val;
            b_d[i]     = iss_b_val;
            a_rdy_d[i] = iss_a_rdy;
            b_rdy_d[i] = iss_b_rdy;
            a_tag_d[i] = iss_a_tag;
            b_tag_d[i] = iss_b_tag;
            st_d[i]    = (iss_a_rdy && iss_b_rdy) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!a_rdy_q[i] && done_rob[a_tag_q[i]]) begin
            a_d[i]     = data_rob[a_tag_q[i]];
            a_rdy_d[i] = 1'b1;
          end
          if (!b_rdy_q[i] && done_rob[b_tag_q[i]]) begin
            b_d[i]     = data_rob[b_tag_q[i]];
            b_rdy_d[i] = 1'b1;
          end
          if (a_rdy_d[i] && b_rdy_d[i]) st_d[i] = ST_READY;
        end
        ST_READY: begin
          if (alu_req_valid && alu_req_ready && sel_idx == rs_index_bits'(i)) st_d[i] = ST_EXEC;
        end
        ST_EXEC: begin
          if (alu_resp_valid && alu_resp_tag == rs_index_bits'(i)) begin
            st_d[i]      = ST_DONE;
            data_rs_d[i] = alu_resp_data;
            done_rs_d[i] = 1'b1;
          end
        end
        ST_DONE: st_d[i] = ST_FREE;
        default: st_d[i] = ST_FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < rs_size; i++) begin
        st_q[i]    <= ST_FREE;
        op_q[i]    <= '0;
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        a_rdy_q[i] <= 1'b0;
        b_rdy_q[i] <= 1'b0;
        a_tag_q[i] <= '0;
        b_tag_q[i] <= '0;
      end
      done_rs_q <= '0;
      data_rs_q <= '0;
    end else begin
      for (int i = 0; i < rs_size; i++) begin
        st_q[i]    <= st_d[i];
        op_q[i]    <= op_d[i];
        a_q[i]     <= a_d[i];
        b_q[i]     <= b_d[i];
        a_rdy_q[i] <= a_rdy_d[i];
        b_rdy_q[i] <= b_rdy_d[i];
        a_tag_q[i] <= a_tag_d[i];
        b_tag_q[i] <= b_tag_d[i];
      end
      done_rs_q <= done_rs_d;
      data_rs_q <= data_rs_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station. The expected values are
// hand-computed from the intended behaviour.
module tb_reservation_station;

  logic               clk = 1'b0;
  logic               rst;
  logic               issue_valid;
  logic [3:0]         issue_op;
  logic               issue_src1_tag;
  logic [31:0]        issue_src1;
  logic               issue_src2_tag;
  logic [31:0]        issue_src2;
  logic [3:0]         alloc_idx;
  logic               rs_full;
  logic [15:0]        done_rob;
  logic [15:0][31:0]  data_rob;
  logic               alu_req_valid;
  logic               alu_req_ready;
  logic [3:0]         alu_req_op;
  logic [31:0]        alu_req_a;
  logic [31:0]        alu_req_b;
  logic [3:0]         alu_req_tag;
  logic               alu_resp_valid;
  logic [3:0]         alu_resp_tag;
  logic [31:0]        alu_resp_data;
  logic [15:0]        done_rs;
  logic [15:0][31:0]  data_rs;
  logic [15:0][2:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  reservation_station dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_src1_tag(issue_src1_tag), .issue_src1(issue_src1),
    .issue_src2_tag(issue_src2_tag), .issue_src2(issue_src2),
    .alloc_idx(alloc_idx), .rs_full(rs_full),
    .done_rob(done_rob), .data_rob(data_rob),
    .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
    .alu_req_op(alu_req_op), .alu_req_a(alu_req_a), .alu_req_b(alu_req_b),
    .alu_req_tag(alu_req_tag),
    .alu_resp_valid(alu_resp_valid), .alu_resp_tag(alu_resp_tag),
    .alu_resp_data(alu_resp_data),
    .done_rs(done_rs), .data_rs(data_rs), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock. Outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic t1, input logic [31:0] s1,
                       input logic t2, input logic [31:0] s2);
    issue_valid    = 1'b1;
    issue_op       = op;
    issue_src1_tag = t1;
    issue_src1     = s1;
    issue_src2_tag = t2;
    issue_src2     = s2;
    tick();
    issue_valid    = 1'b0;
  endtask

  task automatic respond(input logic [3:0] tag, input logic [31:0] data);
    alu_resp_valid = 1'b1;
    alu_resp_tag   = tag;
    alu_resp_data  = data;
    tick();
    alu_resp_valid = 1'b0;
  endtask

  task automatic accept_one();
    alu_req_ready = 1'b1;
    tick();
    alu_req_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 0; issue_op = 0; issue_src1_tag = 0; issue_src1 = 0;
    issue_src2_tag = 0; issue_src2 = 0; done_rob = '0; data_rob = '0;
    alu_req_ready = 0; alu_resp_valid = 0; alu_resp_tag = 0; alu_resp_data = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check_eq("rst_full", rs_full, 0);
    check_eq("rst_alloc", alloc_idx, 0);
    check_eq("rst_valid", alu_req_valid, 0);
    check_eq("rst_done", done_rs, 0);

    // values only: 5 + 7
    issue(4'd1, 0, 5, 0, 7);
    check_eq("v_valid", alu_req_valid, 1);
    check_eq("v_tag", alu_req_tag, 0);
    check_eq("v_a", alu_req_a, 5);
    check_eq("v_b", alu_req_b, 7);
    check_eq("v_op", alu_req_op, 1);
    accept_one();
    check_eq("v_exec_novalid", alu_req_valid, 0);
    respond(4'd0, 32'd12);
    check_eq("v_done", done_rs, 16'h0001);
    check_eq("v_data", data_rs[0], 12);
    check_eq("v_alloc_busy", alloc_idx, 1);
    tick();
    check_eq("v_done_clr", done_rs, 0);
    check_eq("v_alloc_free", alloc_idx, 0);
    check_eq("v_data_hold", data_rs[0], 12);

    // tag wait on ROB entry 3
    issue(4'd2, 1, 3, 0, 4);
    check_eq("w_novalid0", alu_req_valid, 0);
    tick();
    check_eq("w_novalid1", alu_req_valid, 0);
    done_rob[3] = 1'b1; data_rob[3] = 32'd9;
    tick();
    done_rob[3] = 1'b0;
    check_eq("w_valid", alu_req_valid, 1);
    check_eq("w_a", alu_req_a, 9);
    check_eq("w_b", alu_req_b, 4);
    accept_one();
    respond(4'd0, 32'd13);
    check_eq("w_done", done_rs, 16'h0001);
    check_eq("w_data", data_rs[0], 13);
    tick();

    // same-cycle capture from ROB entry 2
    done_rob[2] = 1'b1; data_rob[2] = 32'h55;
    issue(4'd3, 1, 2, 0, 1);
    done_rob[2] = 1'b0;
    check_eq("s_valid", alu_req_valid, 1);
    check_eq("s_a", alu_req_a, 32'h55);
    check_eq("s_b", alu_req_b, 1);
    accept_one();
    // response to a non-EXEC entry is ignored
    respond(4'd5, 32'hbad);
    check_eq("s_stray_done", done_rs, 0);
    check_eq("s_stray_data", data_rs[5], 0);
    respond(4'd0, 32'h56);
    check_eq("s_done", done_rs, 16'h0001);
    tick();

    // fill all 16 entries
    for (int i = 0; i < 16; i++) begin
      check_eq("f_alloc", alloc_idx, i);
      issue(4'(i), 0, i, 0, i + 100);
    end
    check_eq("f_full", rs_full, 1);
    check_eq("f_alloc_full", alloc_idx, 0);
    issue(4'hf, 0, 32'hdead, 0, 32'hbeef);
    check_eq("f_ignored_full", rs_full, 1);
    check_eq("f_ignored_tag", alu_req_tag, 0);
    check_eq("f_ignored_a", alu_req_a, 0);
    alu_req_ready = 1'b1;
    repeat (6) tick();
    alu_req_ready = 1'b0;
    check_eq("f_next_tag", alu_req_tag, 6);
    check_eq("f_next_a", alu_req_a, 6);
    check_eq("f_next_b", alu_req_b, 106);
    respond(4'd5, 32'h500);
    check_eq("f_done5", done_rs, 16'h0020);
    check_eq("f_data5", data_rs[5], 32'h500);
    check_eq("f_still_full", rs_full, 1);
    tick();
    check_eq("f_freed_full", rs_full, 0);
    check_eq("f_freed_alloc", alloc_idx, 5);

    // reset mid-operation with entries still in EXEC
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_eq("r_full", rs_full, 0);
    check_eq("r_valid", alu_req_valid, 0);
    check_eq("r_data5", data_rs[5], 0);
    respond(4'd0, 32'h77);
    check_eq("r_stale_resp", done_rs, 0);

    // priority and backpressure: entries 1 and 3 READY, 0 and 2 wait on tag 7
    issue(4'd0, 1, 7, 0, 0);
    issue(4'd1, 0, 11, 0, 22);
    issue(4'd2, 1, 7, 0, 0);
    issue(4'd3, 0, 33, 0, 44);
    check_eq("p_tag", alu_req_tag, 1);
    check_eq("p_a", alu_req_a, 11);
    check_eq("p_b", alu_req_b, 22);
    check_eq("p_op", alu_req_op, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("p_hold_valid", alu_req_valid, 1);
      check_eq("p_hold_tag", alu_req_tag, 1);
    end
    accept_one();
    check_eq("p_next_tag", alu_req_tag, 3);
    check_eq("p_next_a", alu_req_a, 33);
    check_eq("p_next_op", alu_req_op, 3);
    // a lower-index entry becoming ready takes over the request
    done_rob[7] = 1'b1; data_rob[7] = 32'd70;
    tick();
    done_rob[7] = 1'b0;
    check_eq("p_resel_tag", alu_req_tag, 0);
    check_eq("p_resel_a", alu_req_a, 70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
